// File: rtl/slide_scan.sv
// Round-robin slide-pot scanner: sequences A2D conversions over NUM_CH slots and holds the latest result per slot.
// Optional deadband filtering is enabled by defining SLIDE_DEADBAND_EN.
module slide_scan #(
    parameter int                      NUM_CH   = 6,
    parameter int                      RES_W    = 12,
    parameter int                      CH_W     = 3,
    parameter logic [NUM_CH*CH_W-1:0]  CH_MAP   = {3'd7, 3'd4, 3'd3, 3'd2, 3'd0, 3'd1},
    parameter int                      GAP_CYC  = 0,
    parameter int                      DEADBAND = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic                      strt_cnv,
    output logic [CH_W-1:0]           chnnl,
    input  logic                      cnv_cmplt,
    input  logic [RES_W-1:0]          res,
    output logic [NUM_CH*RES_W-1:0]   pot,
    output logic [NUM_CH-1:0]         pot_vld,
    output logic                      scan_done
);

    localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t              state;
    logic [SLOT_W-1:0]   slot;
    logic [SLOT_W-1:0]   slot_nxt;
    logic [7:0]          gap_cnt;
    logic                last;
    logic                upd;

    function automatic logic [CH_W-1:0] map_ch(input logic [SLOT_W-1:0] s);
        return CH_MAP[int'(s)*CH_W +: CH_W];
    endfunction

`ifdef SLIDE_DEADBAND_EN
    logic [NUM_CH-1:0]   seen;
    logic [RES_W-1:0]    cur;

    // Widened by one bit so the magnitude never wraps.
    function automatic logic [RES_W:0] abs_diff(input logic [RES_W-1:0] a,
                                                input logic [RES_W-1:0] b);
        logic [RES_W:0] x;
        logic [RES_W:0] y;
        x = {1'b0, a};
        y = {1'b0, b};
        return (x >= y) ? (x - y) : (y - x);
    endfunction
`endif

    always_comb begin
        last     = (slot == SLOT_W'(NUM_CH - 1));
        slot_nxt = last ? '0 : slot + 1'b1;
`ifdef SLIDE_DEADBAND_EN
        cur = pot[int'(slot)*RES_W +: RES_W];
        upd = !seen[slot] || (abs_diff(res, cur) > (RES_W+1)'(DEADBAND));
`else
        upd = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= '0;
            gap_cnt   <= '0;
            pot       <= '0;
            pot_vld   <= '0;
            scan_done <= 1'b0;
            strt_cnv  <= 1'b0;
            chnnl     <= map_ch('0);
`ifdef SLIDE_DEADBAND_EN
            seen      <= '0;
`endif
        end else begin
            pot_vld   <= '0;
            scan_done <= 1'b0;
            strt_cnv  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= START;
                        strt_cnv <= 1'b1;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (cnv_cmplt) begin
                        if (upd) begin
                            pot[int'(slot)*RES_W +: RES_W] <= res;
                            pot_vld <= NUM_CH'(1) << slot;
                        end
`ifdef SLIDE_DEADBAND_EN
                        seen[slot] <= 1'b1;
`endif
                        scan_done <= last;
                        slot      <= slot_nxt;
                        chnnl     <= map_ch(slot_nxt);
                        if (GAP_CYC > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else if (en) begin
                            state    <= START;
                            strt_cnv <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    // Leaves after exactly GAP_CYC cycles spent in this state.
                    if (gap_cnt == 8'(GAP_CYC - 1)) begin
                        if (en) begin
                            state    <= START;
                            strt_cnv <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slide_scan.sv
// Directed bench for slide_scan: default instance (GAP_CYC=0) plus a GAP_CYC=3 instance.
module tb_slide_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res = '0;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [71:0] pot;
    logic [5:0]  pot_vld;
    logic        scan_done;

    logic        g_en = 1'b0;
    logic        g_cmplt = 1'b0;
    logic [11:0] g_res = '0;
    logic        g_strt;
    logic [2:0]  g_chnnl;
    logic [71:0] g_pot;
    logic [5:0]  g_pot_vld;
    logic        g_done;

    int checks = 0;
    int errors = 0;
    int ch_map [6] = '{1, 0, 2, 3, 4, 7};

    always #5 clk = ~clk;

    slide_scan dut (
        .clk(clk), .rst(rst), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .pot(pot), .pot_vld(pot_vld),
        .scan_done(scan_done)
    );

    slide_scan #(.GAP_CYC(3)) dut_gap (
        .clk(clk), .rst(rst), .en(g_en), .strt_cnv(g_strt), .chnnl(g_chnnl),
        .cnv_cmplt(g_cmplt), .res(g_res), .pot(g_pot), .pot_vld(g_pot_vld),
        .scan_done(g_done)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strt(input string tag);
        int n = 0;
        while (strt_cnv !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (strt_cnv !== 1'b1) begin
            errors++;
            $display("FAIL %s strt_cnv timeout: got=%b want=1", tag, strt_cnv);
        end
    endtask

    // Assumes START is visible now; returns just after the capture edge.
    task automatic run_conv(input logic [11:0] v);
        step();
        step();
        cnv_cmplt = 1'b1;
        res       = v;
        step();
        cnv_cmplt = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        step();
        step();
        checks++; if (pot !== '0) begin errors++; $display("FAIL rst_pot got=%h want=0", pot); end
        checks++; if (pot_vld !== '0) begin errors++; $display("FAIL rst_vld got=%b want=0", pot_vld); end
        checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", scan_done); end
        checks++; if (strt_cnv !== 1'b0) begin errors++; $display("FAIL rst_strt got=%b want=0", strt_cnv); end
        checks++; if (chnnl !== 3'd1) begin errors++; $display("FAIL rst_chnnl got=%0d want=1", chnnl); end
        rst = 1'b0;
        step();
        checks++; if (strt_cnv !== 1'b0) begin errors++; $display("FAIL idle_no_strt got=%b want=0", strt_cnv); end
    endtask

    task automatic test_gap;
        int n = 0;
        g_en = 1'b1;
        while (g_strt !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (g_strt !== 1'b1) begin errors++; $display("FAIL gap_first_strt got=%b want=1", g_strt); end
        checks++; if (g_chnnl !== 3'd1) begin errors++; $display("FAIL gap_chnnl0 got=%0d want=1", g_chnnl); end
        step();
        step();
        g_cmplt = 1'b1;
        g_res   = 12'h0AA;
        step();
        g_cmplt = 1'b0;
        checks++; if (g_pot[11:0] !== 12'h0AA) begin errors++; $display("FAIL gap_pot got=%h want=0aa", g_pot[11:0]); end
        checks++; if (g_pot_vld !== 6'b000001) begin errors++; $display("FAIL gap_vld got=%b want=000001", g_pot_vld); end
        checks++; if (g_strt !== 1'b0) begin errors++; $display("FAIL gap_n1 got=%b want=0", g_strt); end
        // Spurious completion while in GAP must be ignored.
        g_cmplt = 1'b1;
        g_res   = 12'hFFF;
        step();
        g_cmplt = 1'b0;
        checks++; if (g_strt !== 1'b0) begin errors++; $display("FAIL gap_n2 got=%b want=0", g_strt); end
        checks++; if (g_pot_vld !== 6'b0) begin errors++; $display("FAIL gap_spur_vld got=%b want=0", g_pot_vld); end
        checks++; if (g_pot[11:0] !== 12'h0AA) begin errors++; $display("FAIL gap_spur_pot got=%h want=0aa", g_pot[11:0]); end
        step();
        checks++; if (g_strt !== 1'b0) begin errors++; $display("FAIL gap_n3 got=%b want=0", g_strt); end
        step();
        checks++; if (g_strt !== 1'b1) begin errors++; $display("FAIL gap_n4 got=%b want=1", g_strt); end
        checks++; if (g_chnnl !== 3'd0) begin errors++; $display("FAIL gap_chnnl1 got=%0d want=0", g_chnnl); end
        g_en = 1'b0;
    endtask

    task automatic test_scan;
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int s = k % 6;
            logic [11:0] v = 12'h100 + 12'(s);
            logic [5:0]  oh = 6'b000001 << s;
            wait_strt("scan");
            checks++; if (chnnl !== 3'(ch_map[s])) begin errors++; $display("FAIL scan_chnnl slot%0d got=%0d want=%0d", s, chnnl, ch_map[s]); end
            step();
            checks++; if (strt_cnv !== 1'b0) begin errors++; $display("FAIL scan_strt_width got=%b want=0", strt_cnv); end
            checks++; if (chnnl !== 3'(ch_map[s])) begin errors++; $display("FAIL scan_chnnl_hold got=%0d want=%0d", chnnl, ch_map[s]); end
            step();
            cnv_cmplt = 1'b1;
            res       = v;
            step();
            cnv_cmplt = 1'b0;
            checks++; if (pot[s*12 +: 12] !== v) begin errors++; $display("FAIL scan_pot slot%0d got=%h want=%h", s, pot[s*12 +: 12], v); end
            checks++; if (pot_vld !== oh) begin errors++; $display("FAIL scan_vld got=%b want=%b", pot_vld, oh); end
            checks++; if (scan_done !== (s == 5)) begin errors++; $display("FAIL scan_done slot%0d got=%b want=%b", s, scan_done, s == 5); end
            checks++; if (strt_cnv !== 1'b1) begin errors++; $display("FAIL back_to_back got=%b want=1", strt_cnv); end
        end
    endtask

    task automatic test_en_drop;
        int sc = 0;
        wait_strt("drop0");
        run_conv(12'h110);
        wait_strt("drop1");
        run_conv(12'h111);
        wait_strt("drop2");
        checks++; if (chnnl !== 3'd2) begin errors++; $display("FAIL drop_chnnl2 got=%0d want=2", chnnl); end
        step();
        en = 1'b0;
        step();
        cnv_cmplt = 1'b1;
        res       = 12'h222;
        step();
        cnv_cmplt = 1'b0;
        checks++; if (pot[24 +: 12] !== 12'h222) begin errors++; $display("FAIL drop_pot got=%h want=222", pot[24 +: 12]); end
        checks++; if (pot_vld !== 6'b000100) begin errors++; $display("FAIL drop_vld got=%b want=000100", pot_vld); end
        for (int i = 0; i < 4; i++) begin
            if (strt_cnv === 1'b1) sc++;
            step();
        end
        checks++; if (sc != 0) begin errors++; $display("FAIL drop_idle strt pulses got=%0d want=0", sc); end
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
        step();
        cnv_cmplt = 1'b0;
        checks++; if (pot_vld !== 6'b0) begin errors++; $display("FAIL idle_spur_vld got=%b want=0", pot_vld); end
        checks++; if (pot[36 +: 12] !== 12'h103) begin errors++; $display("FAIL idle_spur_pot got=%h want=103", pot[36 +: 12]); end
        en = 1'b1;
        wait_strt("resume");
        checks++; if (chnnl !== 3'd3) begin errors++; $display("FAIL resume_chnnl got=%0d want=3", chnnl); end
    endtask

    task automatic test_rst_abort;
        step();
        rst = 1'b1;
        en  = 1'b0;
        step();
        rst = 1'b0;
        step();
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
        step();
        cnv_cmplt = 1'b0;
        checks++; if (pot !== '0) begin errors++; $display("FAIL abort_pot got=%h want=0", pot); end
        checks++; if (pot_vld !== 6'b0) begin errors++; $display("FAIL abort_vld got=%b want=0", pot_vld); end
        checks++; if (chnnl !== 3'd1) begin errors++; $display("FAIL abort_chnnl got=%0d want=1", chnnl); end
        checks++; if (strt_cnv !== 1'b0) begin errors++; $display("FAIL abort_strt got=%b want=0", strt_cnv); end
        en = 1'b1;
        wait_strt("abort_resume");
        checks++; if (chnnl !== 3'd1) begin errors++; $display("FAIL abort_slot0 got=%0d want=1", chnnl); end
    endtask

    task automatic test_deadband;
        run_conv(12'h200);
        checks++; if (pot[11:0] !== 12'h200) begin errors++; $display("FAIL db_first got=%h want=200", pot[11:0]); end
        checks++; if (pot_vld !== 6'b000001) begin errors++; $display("FAIL db_first_vld got=%b want=000001", pot_vld); end
        for (int s = 1; s < 6; s++) begin
            wait_strt("db_a");
            run_conv(12'h300 + 12'(s));
        end
        wait_strt("db_b");
        run_conv(12'h203);
`ifdef SLIDE_DEADBAND_EN
        checks++; if (pot[11:0] !== 12'h200) begin errors++; $display("FAIL db_hold got=%h want=200", pot[11:0]); end
        checks++; if (pot_vld !== 6'b0) begin errors++; $display("FAIL db_hold_vld got=%b want=0", pot_vld); end
`else
        checks++; if (pot[11:0] !== 12'h203) begin errors++; $display("FAIL nodb_upd got=%h want=203", pot[11:0]); end
        checks++; if (pot_vld !== 6'b000001) begin errors++; $display("FAIL nodb_vld got=%b want=000001", pot_vld); end
`endif
        for (int s = 1; s < 6; s++) begin
            wait_strt("db_c");
            run_conv(12'h300 + 12'(s));
        end
        checks++; if (scan_done !== 1'b1) begin errors++; $display("FAIL db_scan_done got=%b want=1", scan_done); end
        wait_strt("db_d");
        run_conv(12'h205);
        checks++; if (pot[11:0] !== 12'h205) begin errors++; $display("FAIL db_upd got=%h want=205", pot[11:0]); end
        checks++; if (pot_vld !== 6'b000001) begin errors++; $display("FAIL db_upd_vld got=%b want=000001", pot_vld); end
    endtask

    initial begin
        test_reset();
        test_gap();
        test_scan();
        test_en_drop();
        test_rst_abort();
        test_deadband();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
